dual_port_ram_be: RTL and testbench



---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_port_pipe.sv | 63 ++++++
 rtl/dual_port_ram_be.sv | 166 ++++++++++++++++
 tb/tb_dual_port_ram_be.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package ram_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Even parity: stored bit makes the byte plus parity have an even count of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_port_pipe.sv
// Per-port read pipeline: output/valid registers for 1 or 2 cycles of read
// latency, plus the parity check that travels alongside the data.
module ram_port_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_W        = 32,
  parameter int READ_LATENCY = 1,
  parameter bit PAR_EN       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_vld,
  input  logic [MEM_W-1:0]      rd_word,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  par_err
);

  localparam int NB = DATA_WIDTH / 8;

  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1]                 err_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;
  logic                                  chk_err;

  generate
    if (PAR_EN) begin : g_par
      logic [NB-1:0] mis;
      always_comb begin
        mis = '0;
        for (int i = 0; i < NB; i++)
          mis[i] = byte_parity(rd_word[8*i +: 8]) ^ rd_word[DATA_WIDTH + i];
      end
      assign chk_err = |mis;
    end else begin : g_nopar
      assign chk_err = 1'b0;
    end
  endgenerate

  // Data stages only load on a valid so dout holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_vld;
      err_pipe[1] <= rd_vld & chk_err;
      if (rd_vld) dat_pipe[1] <= rd_word[DATA_WIDTH-1:0];
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        err_pipe[s] <= err_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign dout       = dat_pipe[READ_LATENCY];
  assign dout_valid = vld_pipe[READ_LATENCY];
  assign par_err    = err_pipe[READ_LATENCY];

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, selectable read-during-write and a
// post-reset clear sequencer. Define RAM_PARITY_EN for per-byte even parity.
module dual_port_ram_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_a,
  input  logic [DATA_WIDTH/8-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    dout_valid_a,
  input  logic                    en_b,
  input  logic [DATA_WIDTH/8-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    dout_valid_b,
  output logic                    ready,
  output logic                    collision,
  output logic                    par_err_a,
  output logic                    par_err_b
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int PW     = NB;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int PW     = 0;
`endif
  localparam int        MEM_W = DATA_WIDTH + PW;
  localparam rdw_mode_e MODE  = rdw_mode_e'(RDW_MODE);

  generate
    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
      $error("dual_port_ram_be: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_rl
      $error("dual_port_ram_be: READ_LATENCY must be 1 or 2");
    end
    if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
      $error("dual_port_ram_be: RDW_MODE must be 0, 1 or 2");
    end
  endgenerate

  logic [MEM_W-1:0] mem [DEPTH];

  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic [NUM_PORTS-1:0]                 en_p, acc, wr;
  logic [NUM_PORTS-1:0][NB-1:0]         we_p;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_p;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] din_p, dout_p;
  logic [NUM_PORTS-1:0]                 dvld_p, perr_p;

  assign en_p   = {en_b, en_a};
  assign we_p   = {we_b, we_a};
  assign addr_p = {addr_b, addr_a};
  assign din_p  = {din_b, din_a};

  // No access is taken on the reset edge; the clear rewrites everything anyway.
  assign acc = en_p & {NUM_PORTS{ready & ~rst}};
  always_comb begin
    wr = '0;
    for (int p = 0; p < NUM_PORTS; p++) wr[p] = acc[p] & (|we_p[p]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: ready <= 1'b1;
      endcase
    end
  end

  // Port B is applied first so port A's bytes win on an overlapping write.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (acc[p]) begin
          for (int i = 0; i < NB; i++) begin
            if (we_p[p][i]) begin
              mem[addr_p[p]][8*i +: 8] <= din_p[p][8*i +: 8];
`ifdef RAM_PARITY_EN
              mem[addr_p[p]][DATA_WIDTH + i] <= byte_parity(din_p[p][8*i +: 8]);
`endif
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= (&acc) && (addr_p[0] == addr_p[1]) && (|wr);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [MEM_W-1:0] old_w, new_w, rd_word;
    logic             rd_vld;

    assign old_w = mem[addr_p[p]];

    always_comb begin
      new_w = old_w;
      for (int i = 0; i < NB; i++) begin
        if (we_p[p][i]) begin
          new_w[8*i +: 8] = din_p[p][8*i +: 8];
`ifdef RAM_PARITY_EN
          new_w[DATA_WIDTH + i] = byte_parity(din_p[p][8*i +: 8]);
`endif
        end
      end
    end

    assign rd_word = (MODE == WRITE_FIRST) ? new_w : old_w;
    assign rd_vld  = acc[p] & (~wr[p] | (MODE != NO_CHANGE));

    ram_port_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MEM_W       (MEM_W),
      .READ_LATENCY(READ_LATENCY),
      .PAR_EN      (PAR_EN)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .rd_vld    (rd_vld),
      .rd_word   (rd_word),
      .dout      (dout_p[p]),
      .dout_valid(dvld_p[p]),
      .par_err   (perr_p[p])
    );
  end

  assign dout_a       = dout_p[0];
  assign dout_b       = dout_p[1];
  assign dout_valid_a = dvld_p[0];
  assign dout_valid_b = dvld_p[1];
  assign par_err_a    = perr_p[0];
  assign par_err_b    = perr_p[1];

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: three RAM builds (RL1/READ_FIRST, RL2/WRITE_FIRST,
// RL1/NO_CHANGE) share one stimulus stream.
module tb_dual_port_ram_be;

  logic        clk, rst;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b, addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [2:0][31:0] dout_a, dout_b;
  logic [2:0]       vld_a, vld_b, rdy, col, pe_a, pe_b;

  int n_vec = 0;
  int n_err = 0;

  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[0]), .dout_valid_a(vld_a[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[0]), .dout_valid_b(vld_b[0]),
    .ready(rdy[0]), .collision(col[0]), .par_err_a(pe_a[0]), .par_err_b(pe_b[0]));

  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[1]), .dout_valid_a(vld_a[1]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[1]), .dout_valid_b(vld_b[1]),
    .ready(rdy[1]), .collision(col[1]), .par_err_a(pe_a[1]), .par_err_b(pe_b[1]));

  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(2)) dut2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[2]), .dout_valid_a(vld_a[2]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[2]), .dout_valid_b(vld_b[2]),
    .ready(rdy[2]), .collision(col[2]), .par_err_a(pe_a[2]), .par_err_b(pe_b[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ea; logic [3:0] wa; logic [3:0] aa; logic [31:0] da;
    logic       eb; logic [3:0] wb; logic [3:0] ab; logic [31:0] db;
    logic       xva; logic [31:0] xa;
    logic       xvb; logic [31:0] xb;
    logic       xcol;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
  endtask

  // Steps until dut0 reports ready, counting cycles and any stray valid.
  task automatic wait_ready(output int n, output int stray);
    n = 0; stray = 0;
    while (!rdy[0] && n < 40) begin
      step();
      n++;
      if ((|vld_a) || (|vld_b)) stray++;
    end
  endtask

  initial begin
    int n, stray;

    //                 ea wa    aa    da            eb wb    ab    db            xva xa            xvb xb            xcol
    tbl[0]  = '{1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 4'h5, 4'd5, 32'h11223344, 1'b1, 4'h0, 4'd5, 32'h0,        1'b1, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD, 1'b1};
    tbl[2]  = '{1'b1, 4'h0, 4'd5, 32'h0,        1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 32'hAA22CC44, 1'b0, 32'hAABBCCDD, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 4'd3, 32'h00000001, 1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 32'h0,        1'b0, 32'hAABBCCDD, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 4'd3, 32'h00000002, 1'b1, 4'h0, 4'd3, 32'h0,        1'b1, 32'h1,        1'b1, 32'h1,        1'b1};
    tbl[5]  = '{1'b1, 4'h0, 4'd3, 32'h0,        1'b1, 4'h0, 4'd3, 32'h0,        1'b1, 32'h2,        1'b1, 32'h2,        1'b0};
    tbl[6]  = '{1'b1, 4'h1, 4'd7, 32'h000000FF, 1'b1, 4'h3, 4'd7, 32'h0000AB00, 1'b1, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 4'h0, 4'd7, 32'h0,        1'b1, 4'h0, 4'd7, 32'h0,        1'b1, 32'h0000ABFF, 1'b1, 32'h0000ABFF, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 32'h0000ABFF, 1'b0, 32'h0000ABFF, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 4'd5, 32'h0,        1'b1, 4'hC, 4'd5, 32'h55667788, 1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1};
    tbl[10] = '{1'b1, 4'h0, 4'd5, 32'h0,        1'b1, 4'h0, 4'd0, 32'h0,        1'b1, 32'h5566CC44, 1'b1, 32'h0,        1'b0};
    tbl[11] = '{1'b1, 4'h0, 4'd15, 32'h0,       1'b1, 4'h0, 4'd14, 32'h0,       1'b1, 32'h0,        1'b1, 32'h0,        1'b0};

    // Reset state across all three builds
    rst = 1'b1;
    drv(0, 4'h0, 4'd0, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    step(); step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_dout_a%0d", d), dout_a[d], 32'h0);
      chk($sformatf("rst_dout_b%0d", d), dout_b[d], 32'h0);
      chk($sformatf("rst_flags%0d", d),
          {26'h0, vld_a[d], vld_b[d], rdy[d], col[d], pe_a[d], pe_b[d]}, 32'h0);
    end

    // Clear sequence: requests during clear are dropped, ready after 16 cycles
    rst = 1'b0;
    drv(1, 4'h0, 4'd2, 32'h0, 1, 4'h0, 4'd9, 32'h0);
    wait_ready(n, stray);
    chk("clear_cycles", n, 16);
    chk("clear_stray_valid", stray, 0);

    for (int i = 0; i < 16; i++) begin
      drv(1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(15 - i), 32'h0);
      step();
      chk($sformatf("clr_rd_a%0d", i), {vld_a[0], pe_a[0], dout_a[0][29:0]}, 32'h80000000);
      chk($sformatf("clr_rd_b%0d", i), {vld_b[0], pe_b[0], dout_b[0][29:0]}, 32'h80000000);
      chk($sformatf("clr_hi_a%0d", i), {30'h0, dout_a[0][31:30]}, 32'h0);
    end

    // Table vectors, checked on the READ_FIRST / latency-1 build
    for (int v = 0; v < 12; v++) begin
      drv(tbl[v].ea, tbl[v].wa, tbl[v].aa, tbl[v].da, tbl[v].eb, tbl[v].wb, tbl[v].ab, tbl[v].db);
      step();
      chk($sformatf("v%0d_vld_a", v), vld_a[0], tbl[v].xva);
      chk($sformatf("v%0d_dout_a", v), dout_a[0], tbl[v].xa);
      chk($sformatf("v%0d_vld_b", v), vld_b[0], tbl[v].xvb);
      chk($sformatf("v%0d_dout_b", v), dout_b[0], tbl[v].xb);
      chk($sformatf("v%0d_col", v), col[0], tbl[v].xcol);
    end

    // Read-during-write on addr 3 across the three modes
    drv(1, 4'hF, 4'd3, 32'h1, 0, 4'h0, 4'd0, 32'h0);
    step();
    drv(1, 4'h0, 4'd3, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    step();
    chk("rdw_s2_wf", {vld_a[1], dout_a[1][30:0]}, 32'h80000001);
    chk("rdw_s2_nc", {vld_a[2], dout_a[2][30:0]}, 32'h80000001);
    drv(1, 4'hF, 4'd3, 32'h2, 0, 4'h0, 4'd0, 32'h0);
    step();
    chk("rdw_rf", {vld_a[0], dout_a[0][30:0]}, 32'h80000001);
    chk("rdw_nc", {vld_a[2], dout_a[2][30:0]}, 32'h00000001);
    chk("rdw_wf_prev", {vld_a[1], dout_a[1][30:0]}, 32'h80000001);
    drv(0, 4'h0, 4'd0, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    step();
    chk("rdw_wf_lat2", {vld_a[1], dout_a[1][30:0]}, 32'h80000002);
    chk("rdw_rf_idle", {vld_a[0], dout_a[0][30:0]}, 32'h00000001);
    step();
    chk("rdw_wf_one_cycle", {vld_a[1], dout_a[1][30:0]}, 32'h00000002);

    // Reset in the middle of streaming reads
    drv(1, 4'h0, 4'd5, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    step();
    chk("strm_rd0", dout_a[0], 32'h5566CC44);
    step();
    chk("strm_rd1_lat2", {31'h0, vld_a[1]}, 32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_flags", {26'h0, vld_a[0], vld_a[1], vld_a[2], rdy[0], rdy[1], col[0]}, 32'h0);
    chk("mid_rst_dout", dout_a[0], 32'h0);
    rst = 1'b0;
    drv(1, 4'hF, 4'd0, 32'hFFFFFFFF, 1, 4'hF, 4'd1, 32'hFFFFFFFF);
    wait_ready(n, stray);
    chk("reclear_cycles", n, 16);
    chk("reclear_stray_valid", stray, 0);
    drv(1, 4'h0, 4'd5, 32'h0, 1, 4'h0, 4'd0, 32'h0);
    step();
    chk("reclear_rd5", {vld_a[0], dout_a[0][30:0]}, 32'h80000000);
    chk("reclear_rd0", {vld_b[0], dout_b[0][30:0]}, 32'h80000000);

`ifdef RAM_PARITY_EN
    drv(1, 4'hF, 4'd4, 32'h12345678, 0, 4'h0, 4'd0, 32'h0);
    step();
    dut0.mem[4][0] = ~dut0.mem[4][0];
    drv(1, 4'h0, 4'd4, 32'h0, 1, 4'h0, 4'd5, 32'h0);
    step();
    chk("par_flip", {30'h0, vld_a[0], pe_a[0]}, 32'h3);
    chk("par_clean", {30'h0, vld_b[0], pe_b[0]}, 32'h2);
    drv(0, 4'h0, 4'd0, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    step();
    chk("par_idle", {30'h0, vld_a[0], pe_a[0]}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
